// File: rtl/rgb_pwm_fader_if.sv
// Signal bundle between the duty-code source and the PWM LED driver.
interface rgb_pwm_fader_if #(
   parameter int unsigned CHANNELS = 3,
   parameter int unsigned DUTY_W   = 2
);
   logic [CHANNELS*DUTY_W-1:0] duty_in;
   logic                       fade_en;
   logic [CHANNELS-1:0]        pwm_out;
   logic                       period_start;
   logic                       busy;

   modport master (
      output duty_in, fade_en,
      input  pwm_out, period_start, busy
   );

   modport slave (
      input  duty_in, fade_en,
      output pwm_out, period_start, busy
   );
endinterface

// File: rtl/rgb_pwm_fader.sv
// Multi-channel PWM LED driver; duty changes land only on period boundaries,
// either as a jump or as a one-code-per-period fade.
module rgb_pwm_fader #(
   parameter int unsigned CHANNELS = 3,
   parameter int unsigned DUTY_W   = 2,
   parameter int unsigned PRESCALE = 3125
) (
   input logic            clock,
   input logic            reset,
   rgb_pwm_fader_if.slave bus
);
   localparam int unsigned PC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PC_W-1:0] PC_LAST = PC_W'(PRESCALE - 1);

   logic [PC_W-1:0]   pc;
   logic [DUTY_W-1:0] ph;
   logic [DUTY_W-1:0] ph_next;
   logic [DUTY_W-1:0] target_q [CHANNELS];
   logic [DUTY_W-1:0] cur      [CHANNELS];
   logic [DUTY_W-1:0] cur_next [CHANNELS];
   logic [CHANNELS-1:0] pwm_next;
   logic tick;
   logic boundary;
   logic busy_any;

   assign tick     = (pc == PC_LAST);
   assign boundary = tick && (ph == {DUTY_W{1'b1}});
   assign ph_next  = tick ? ph + DUTY_W'(1) : ph;

   // Next duty per channel; compare uses the values being loaded so the output has no lag.
   always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
         cur_next[c] = cur[c];
         if (boundary) begin
            if (!bus.fade_en)
               cur_next[c] = target_q[c];
            else if (cur[c] < target_q[c])
               cur_next[c] = cur[c] + DUTY_W'(1);
            else if (cur[c] > target_q[c])
               cur_next[c] = cur[c] - DUTY_W'(1);
         end
         pwm_next[c] = (ph_next < cur_next[c]);
      end
   end

   always_comb begin
      busy_any = 1'b0;
      for (int c = 0; c < CHANNELS; c++)
         if (cur[c] != target_q[c])
            busy_any = 1'b1;
   end

   assign bus.busy = busy_any;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc               <= '0;
         ph               <= '0;
         bus.pwm_out      <= '0;
         bus.period_start <= 1'b0;
         for (int c = 0; c < CHANNELS; c++) begin
            target_q[c] <= '0;
            cur[c]      <= '0;
         end
      end else begin
         pc               <= tick ? '0 : pc + PC_W'(1);
         ph               <= ph_next;
         bus.pwm_out      <= pwm_next;
         bus.period_start <= boundary;
         for (int c = 0; c < CHANNELS; c++) begin
            target_q[c] <= bus.duty_in[c*DUTY_W +: DUTY_W];
            cur[c]      <= cur_next[c];
         end
      end
   end
endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Randomised and directed bench for rgb_pwm_fader against a period-level reference model.
module tb_rgb_pwm_fader;
   localparam int CH  = 3;
   localparam int DW  = 2;
   localparam int PS  = 4;
   localparam int PER = PS * (1 << DW);
   localparam int DMASK = (1 << DW) - 1;

   logic clock = 1'b0;
   logic reset;

   rgb_pwm_fader_if #(.CHANNELS(CH), .DUTY_W(DW)) bus ();

   rgb_pwm_fader #(.CHANNELS(CH), .DUTY_W(DW), .PRESCALE(PS)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;
   int t;            // rising edges since reset release
   int cur_m [CH];   // duty in force for the current period
   int tq_m  [CH];   // duty_in as captured at the last edge
   int hi_cnt[CH];

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0d, time %0t)", tag, got, exp, t, $time);
      end
   endtask

   function automatic int exp_pwm();
      int phase = (t % PER) / PS;
      int v = 0;
      for (int c = 0; c < CH; c++)
         if (phase < cur_m[c]) v |= (1 << c);
      return v;
   endfunction

   function automatic int exp_busy();
      for (int c = 0; c < CH; c++)
         if (cur_m[c] != tq_m[c]) return 1;
      return 0;
   endfunction

   task automatic model_reset();
      t = 0;
      for (int c = 0; c < CH; c++) begin
         cur_m[c] = 0;
         tq_m[c]  = 0;
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, "/pwm"},  int'(bus.pwm_out), exp_pwm());
      check({tag, "/ps"},   int'(bus.period_start), (t > 0 && t % PER == 0) ? 1 : 0);
      check({tag, "/busy"}, int'(bus.busy), exp_busy());
   endtask

   // One clock: advance the model by the period rules, then compare.
   task automatic step();
      int old_tq[CH];
      @(posedge clock);
      if (!reset) begin
         old_tq = tq_m;
         t++;
         if (t % PER == 0) begin
            for (int c = 0; c < CH; c++) begin
               if (!bus.fade_en)            cur_m[c] = old_tq[c];
               else if (cur_m[c] < old_tq[c]) cur_m[c] = cur_m[c] + 1;
               else if (cur_m[c] > old_tq[c]) cur_m[c] = cur_m[c] - 1;
            end
         end
         for (int c = 0; c < CH; c++)
            tq_m[c] = int'(bus.duty_in >> (c * DW)) & DMASK;
      end
      #1 check_outputs("cyc");
   endtask

   task automatic wait_boundary();
      bit seen = 1'b0;
      for (int i = 0; i < PER + 2 && !seen; i++) begin
         step();
         if (bus.period_start) seen = 1'b1;
      end
      check("wait_boundary", int'(seen), 1);
   endtask

   // Counts high cycles per channel starting in the current period_start cycle.
   task automatic count_period();
      for (int c = 0; c < CH; c++) hi_cnt[c] = int'(bus.pwm_out[c]);
      repeat (PER - 1) begin
         step();
         for (int c = 0; c < CH; c++) hi_cnt[c] += int'(bus.pwm_out[c]);
      end
   endtask

   initial begin
      int hi;
      reset = 1'b1;
      bus.duty_in = '0;
      bus.fade_en = 1'b0;
      model_reset();
      repeat (3) step();
      reset = 1'b0;

      // First boundary lands on the PER-th edge after release.
      repeat (PER - 1) step();
      check("pre_first_ps", int'(bus.period_start), 0);
      step();
      check("first_ps", int'(bus.period_start), 1);
      repeat (PER) step();

      // Static duties 1/2/3 without fading.
      bus.duty_in = 6'b11_10_01;
      wait_boundary(); wait_boundary();
      count_period();
      check("jump_ch0", hi_cnt[0], 1 * PS);
      check("jump_ch1", hi_cnt[1], 2 * PS);
      check("jump_ch2", hi_cnt[2], 3 * PS);

      // All-zero then all-max.
      bus.duty_in = 6'b00_00_00;
      wait_boundary(); wait_boundary();
      count_period();
      for (int c = 0; c < CH; c++) check("zero_hi", hi_cnt[c], 0);
      bus.duty_in = 6'b11_11_11;
      wait_boundary(); wait_boundary();
      count_period();
      for (int c = 0; c < CH; c++) check("max_hi", hi_cnt[c], 3 * PS);

      // Fade ch0 up 0 -> 3.
      bus.duty_in = 6'b00_00_00;
      wait_boundary(); wait_boundary();
      bus.fade_en = 1'b1;
      bus.duty_in = 6'b00_00_11;
      for (int k = 0; k < 3; k++) begin
         wait_boundary();
         count_period();
         check("fade_up_hi", hi_cnt[0], (k + 1) * PS);
         check("fade_up_busy", int'(bus.busy), (k < 2) ? 1 : 0);
      end
      // Target dropped one edge before a boundary: that boundary still sees 3.
      bus.duty_in = 6'b00_00_00;
      wait_boundary();
      count_period();
      check("fade_late_hi", hi_cnt[0], 3 * PS);
      for (int k = 0; k < 3; k++) begin
         wait_boundary();
         count_period();
         check("fade_dn_hi", hi_cnt[0], (2 - k) * PS);
      end

      // Mid-period change does not disturb the running period.
      bus.fade_en = 1'b0;
      bus.duty_in = 6'b00_00_01;
      wait_boundary(); wait_boundary();
      wait_boundary();
      hi = int'(bus.pwm_out[0]);
      repeat (4) begin step(); hi += int'(bus.pwm_out[0]); end
      bus.duty_in = 6'b00_00_11;
      repeat (PER - 5) begin step(); hi += int'(bus.pwm_out[0]); end
      check("midchg_keep", hi, PS);
      wait_boundary();
      count_period();
      check("midchg_next", hi_cnt[0], 3 * PS);

      // Random duties and fade mode.
      repeat (600) begin
         if ($urandom_range(0, 7) == 0) bus.duty_in = 6'($urandom);
         if ($urandom_range(0, 31) == 0) bus.fade_en = 1'($urandom);
         step();
      end

      // Asynchronous reset mid-period while outputs are high.
      bus.fade_en = 1'b0;
      bus.duty_in = 6'b11_11_11;
      wait_boundary(); wait_boundary();
      wait_boundary();
      step(); step();
      check("pre_rst_pwm", int'(bus.pwm_out), 7);
      #3 reset = 1'b1;
      model_reset();
      #1;
      check("async_rst_pwm",  int'(bus.pwm_out), 0);
      check("async_rst_ps",   int'(bus.period_start), 0);
      check("async_rst_busy", int'(bus.busy), 0);
      repeat (2) step();
      reset = 1'b0;
      repeat (PER - 1) step();
      check("rst_pre_ps", int'(bus.period_start), 0);
      step();
      check("rst_first_ps", int'(bus.period_start), 1);
      count_period();
      for (int c = 0; c < CH; c++) check("rst_first_period", hi_cnt[c], 3 * PS);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule
